// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline sequencer.
// State encoding, the per-stage control word and the fixed control patterns.
package pipe_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    MWAIT = 2'd2,
    HALT  = 2'd3
  } pstate_t;

  // en bit order, MSB first: PC, IF/DEC, DEC/EX, EX/MEM, MEM/WB
  typedef struct packed {
    logic [4:0] en;
    logic       dec_flush;
    logic       ex_flush;
  } pipe_ctl_t;

  localparam int EN_PC  = 4;
  localparam int EN_IFD = 3;
  localparam int EN_DEX = 2;
  localparam int EN_EXM = 1;
  localparam int EN_MWB = 0;

  // Performance counter slots
  localparam int NUM_CNT = 5;
  localparam int CNT_CYC_IX = 0;
  localparam int CNT_RET_IX = 1;
  localparam int CNT_LU_IX  = 2;
  localparam int CNT_MW_IX  = 3;
  localparam int CNT_BR_IX  = 4;

  localparam pipe_ctl_t CTL_FREEZE  = '{en: 5'b00000, dec_flush: 1'b0, ex_flush: 1'b0};
  localparam pipe_ctl_t CTL_RESET   = '{en: 5'b00000, dec_flush: 1'b1, ex_flush: 1'b1};
  localparam pipe_ctl_t CTL_INIT    = '{en: 5'b01111, dec_flush: 1'b1, ex_flush: 1'b1};
  localparam pipe_ctl_t CTL_RUN     = '{en: 5'b11111, dec_flush: 1'b0, ex_flush: 1'b0};
  localparam pipe_ctl_t CTL_BRANCH  = '{en: 5'b11111, dec_flush: 1'b1, ex_flush: 1'b1};
  localparam pipe_ctl_t CTL_LWSTALL = '{en: 5'b00111, dec_flush: 1'b0, ex_flush: 1'b1};
  localparam pipe_ctl_t CTL_IMISS   = '{en: 5'b01111, dec_flush: 1'b1, ex_flush: 1'b0};

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard/memory request inputs and stage-control outputs of the sequencer.
// master = hazard unit / memories / pipeline side, slave = pipe_ctrl.
interface pipe_ctrl_if;
  logic       LW_STALL;
  logic       BR_TAKEN;
  logic       IMEM_READY;
  logic       DMEM_REQ;
  logic       DMEM_ACK;
  logic       PC_EN;
  logic       IF_DEC_EN;
  logic       DEC_EX_EN;
  logic       EX_MEM_EN;
  logic       MEM_WB_EN;
  logic       DEC_FLUSH;
  logic       EX_FLUSH;
  logic       HALTED;
  logic [1:0] STATE;

  modport master (
    output LW_STALL, BR_TAKEN, IMEM_READY, DMEM_REQ, DMEM_ACK,
    input  PC_EN, IF_DEC_EN, DEC_EX_EN, EX_MEM_EN, MEM_WB_EN,
    input  DEC_FLUSH, EX_FLUSH, HALTED, STATE
  );

  modport slave (
    input  LW_STALL, BR_TAKEN, IMEM_READY, DMEM_REQ, DMEM_ACK,
    output PC_EN, IF_DEC_EN, DEC_EX_EN, EX_MEM_EN, MEM_WB_EN,
    output DEC_FLUSH, EX_FLUSH, HALTED, STATE
  );
endinterface

// File: rtl/pipe_perf_cnt.sv
// Performance counters for the pipeline sequencer (present only with PIPE_PERF_CNT_EN).
// One wrapping counter per inc_i bit; all clear on reset and hold while frz_i.
`ifdef PIPE_PERF_CNT_EN
module pipe_perf_cnt #(
  parameter int PERF_W  = 32,
  parameter int NUM_CNT = 5
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             frz_i,
  input  logic [NUM_CNT-1:0]               inc_i,
  output logic [NUM_CNT-1:0][PERF_W-1:0]   cnt_o
);

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    logic [PERF_W-1:0] cnt_q, cnt_d;

    // Next value: bump on event unless frozen, wraps naturally
    always_comb begin
      cnt_d = cnt_q;
      if (!frz_i && inc_i[g]) cnt_d = cnt_q + 1'b1;
    end

    // Counter register
    always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
    end

    assign cnt_o[g] = cnt_q;
  end

endmodule
`endif

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 5-stage core: merges hazard requests with
// IMEM/DMEM wait states into per-stage enables and bubble inserts,
// flushes after reset and halts on a DMEM timeout.
// Optional macro PIPE_PERF_CNT_EN adds the CNT_* performance counter ports.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int INIT_FLUSH_CYC = 2,
  parameter int DMEM_TMO       = 16,
  parameter int PERF_W         = 32
) (
  input  logic              CLK,
  input  logic              RST,
  pipe_ctrl_if.slave        bus
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] CNT_CYC,
  output logic [PERF_W-1:0] CNT_RET,
  output logic [PERF_W-1:0] CNT_LU,
  output logic [PERF_W-1:0] CNT_MW,
  output logic [PERF_W-1:0] CNT_BR
`endif
);

  localparam int TMO_W = $clog2(DMEM_TMO + 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(DMEM_TMO - 1);
  localparam logic [TMO_W-1:0] TMO_MAX   = '1;
  localparam logic [2:0]       INIT_LAST = 3'(INIT_FLUSH_CYC - 1);

  pstate_t          state_q, state_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [2:0]       init_cnt_q, init_cnt_d;
  pipe_ctl_t        ctl;
  logic             mem_hold;

  // A load/store that is not completing this cycle freezes the whole pipe
  assign mem_hold = bus.DMEM_REQ & ~bus.DMEM_ACK;

  // State and counter registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= INIT;
      tmo_cnt_q  <= '0;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tmo_cnt_q  <= tmo_cnt_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Next state: init flush countdown, DMEM wait tracking, timeout to HALT
  always_comb begin
    state_d    = state_q;
    tmo_cnt_d  = tmo_cnt_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      INIT: begin
        if (init_cnt_q >= INIT_LAST) begin
          state_d    = RUN;
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + 3'd1;
        end
      end
      RUN: begin
        tmo_cnt_d = '0;
        if (mem_hold) state_d = MWAIT;
      end
      MWAIT: begin
        if (!mem_hold) begin
          // ACK cycle already issues normal controls, so no dead cycle on return
          state_d   = RUN;
          tmo_cnt_d = '0;
        end else begin
          tmo_cnt_d = (tmo_cnt_q == TMO_MAX) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
          if (tmo_cnt_d >= TMO_LAST) begin
            state_d   = HALT;
            tmo_cnt_d = '0;
          end
        end
      end
      HALT:    state_d = HALT;
      default: state_d = INIT;
    endcase
  end

  // Stage controls: reset/init patterns, then the RUN/MWAIT priority mux
  always_comb begin
    ctl = CTL_FREEZE;
    if (RST) begin
      ctl = CTL_RESET;
    end else begin
      case (state_q)
        INIT: ctl = CTL_INIT;
        RUN, MWAIT: begin
          if (mem_hold)             ctl = CTL_FREEZE;
          else if (bus.BR_TAKEN)    ctl = CTL_BRANCH;
          else if (bus.LW_STALL)    ctl = CTL_LWSTALL;
          else if (!bus.IMEM_READY) ctl = CTL_IMISS;
          else                      ctl = CTL_RUN;
        end
        default: ctl = CTL_FREEZE;
      endcase
    end
  end

  assign bus.PC_EN     = ctl.en[EN_PC];
  assign bus.IF_DEC_EN = ctl.en[EN_IFD];
  assign bus.DEC_EX_EN = ctl.en[EN_DEX];
  assign bus.EX_MEM_EN = ctl.en[EN_EXM];
  assign bus.MEM_WB_EN = ctl.en[EN_MWB];
  assign bus.DEC_FLUSH = ctl.dec_flush;
  assign bus.EX_FLUSH  = ctl.ex_flush;
  assign bus.HALTED    = (state_q == HALT);
  assign bus.STATE     = state_q;

`ifdef PIPE_PERF_CNT_EN
  logic                            run_like;
  logic [NUM_CNT-1:0]              cnt_inc;
  logic [NUM_CNT-1:0][PERF_W-1:0]  cnt_val;

  assign run_like = (state_q == RUN) || (state_q == MWAIT);

  // Event strobes; branch and load-use only count when they win the mux
  always_comb begin
    cnt_inc             = '0;
    cnt_inc[CNT_CYC_IX] = 1'b1;
    cnt_inc[CNT_RET_IX] = run_like & ctl.en[EN_MWB];
    cnt_inc[CNT_LU_IX]  = run_like & ~mem_hold & ~bus.BR_TAKEN & bus.LW_STALL;
    cnt_inc[CNT_MW_IX]  = (state_q == MWAIT);
    cnt_inc[CNT_BR_IX]  = run_like & ~mem_hold & bus.BR_TAKEN;
  end

  pipe_perf_cnt #(
    .PERF_W  (PERF_W),
    .NUM_CNT (NUM_CNT)
  ) u_perf (
    .clk_i (CLK),
    .rst_i (RST),
    .frz_i (state_q == HALT),
    .inc_i (cnt_inc),
    .cnt_o (cnt_val)
  );

  assign CNT_CYC = cnt_val[CNT_CYC_IX];
  assign CNT_RET = cnt_val[CNT_RET_IX];
  assign CNT_LU  = cnt_val[CNT_LU_IX];
  assign CNT_MW  = cnt_val[CNT_MW_IX];
  assign CNT_BR  = cnt_val[CNT_BR_IX];
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: stimulus pushes expected per-cycle controls,
// a negedge monitor pops and compares them.
module tb_pipe_ctrl;
  import pipe_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  pipe_ctrl_if bus ();

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] cnt_cyc, cnt_ret, cnt_lu, cnt_mw, cnt_br;
`endif

  pipe_ctrl #(
    .INIT_FLUSH_CYC (2),
    .DMEM_TMO       (16),
    .PERF_W         (32)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
`ifdef PIPE_PERF_CNT_EN
    ,
    .CNT_CYC (cnt_cyc),
    .CNT_RET (cnt_ret),
    .CNT_LU  (cnt_lu),
    .CNT_MW  (cnt_mw),
    .CNT_BR  (cnt_br)
`endif
  );

  typedef struct {
    bit          chk;
    logic [4:0]  en;
    logic        df;
    logic        ef;
    logic [1:0]  st;
    logic        h;
    bit          chk_cnt;
    int unsigned cyc, ret, lu, mw, br;
    string       nm;
  } exp_t;

  localparam logic [4:0] ALL  = 5'b11111;
  localparam logic [4:0] NONE = 5'b00000;
  localparam logic [4:0] LUS  = 5'b00111;
  localparam logic [4:0] NOPC = 5'b01111;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc_since = 0;
  bit          cnt_pend = 0;
  int unsigned pend_ret, pend_lu, pend_mw, pend_br;

  task automatic cmp(input string nm, input string what, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s.%s: got %0h expected %0h", nm, what, act, exp);
    end
  endtask

  // One cycle: drive inputs after the edge and queue what that cycle must show
  task automatic step(input bit rst, lw, br, imr, req, ack,
                      input logic [4:0] en, input bit df, ef, input logic [1:0] st,
                      input bit h, input string nm, input bit chk = 1'b1);
    exp_t e;
    @(posedge CLK); #1;
    RST            = rst;
    bus.LW_STALL   = lw;
    bus.BR_TAKEN   = br;
    bus.IMEM_READY = imr;
    bus.DMEM_REQ   = req;
    bus.DMEM_ACK   = ack;
    e.chk = chk; e.en = en; e.df = df; e.ef = ef; e.st = st; e.h = h; e.nm = nm;
    e.chk_cnt = cnt_pend; e.cyc = cyc_since;
    e.ret = pend_ret; e.lu = pend_lu; e.mw = pend_mw; e.br = pend_br;
    cnt_pend = 1'b0;
    sbq.push_back(e);
    if (rst) cyc_since = 0;
    else     cyc_since++;
  endtask

  // Monitor: every cycle the DUT presents a control word; compare against the queue head
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        if (e.chk) begin
          cmp(e.nm, "en",     int'({bus.PC_EN, bus.IF_DEC_EN, bus.DEC_EX_EN, bus.EX_MEM_EN, bus.MEM_WB_EN}), int'(e.en));
          cmp(e.nm, "dflush", int'(bus.DEC_FLUSH), int'(e.df));
          cmp(e.nm, "eflush", int'(bus.EX_FLUSH),  int'(e.ef));
          cmp(e.nm, "state",  int'(bus.STATE),     int'(e.st));
          cmp(e.nm, "halted", int'(bus.HALTED),    int'(e.h));
        end
`ifdef PIPE_PERF_CNT_EN
        if (e.chk_cnt) begin
          cmp(e.nm, "cnt_cyc", int'(cnt_cyc), int'(e.cyc));
          cmp(e.nm, "cnt_ret", int'(cnt_ret), int'(e.ret));
          cmp(e.nm, "cnt_lu",  int'(cnt_lu),  int'(e.lu));
          cmp(e.nm, "cnt_mw",  int'(cnt_mw),  int'(e.mw));
          cmp(e.nm, "cnt_br",  int'(cnt_br),  int'(e.br));
        end
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.LW_STALL = 0; bus.BR_TAKEN = 0; bus.IMEM_READY = 1;
    bus.DMEM_REQ = 0; bus.DMEM_ACK = 0;

    // T1 reset, two init-flush cycles, then RUN
    repeat (3) step(1,0,0,1,0,0, NONE,1,1, 2'd0,0, "rst");
    step(0,0,0,1,0,0, NOPC,1,1, 2'd0,0, "init0");
    step(0,0,0,1,0,0, NOPC,1,1, 2'd0,0, "init1");
    step(0,0,0,1,0,0, ALL, 0,0, 2'd1,0, "run");

    // T2 load-use stall
    step(0,1,0,1,0,0, LUS, 0,1, 2'd1,0, "lw");
    step(0,0,0,1,0,0, ALL, 0,0, 2'd1,0, "lw_next");

    // T3 DMEM wait, ACK on third cycle after request
    step(0,0,0,1,1,0, NONE,0,0, 2'd1,0, "mw_f0");
    step(0,0,0,1,1,0, NONE,0,0, 2'd2,0, "mw_f1");
    step(0,0,0,1,1,0, NONE,0,0, 2'd2,0, "mw_f2");
    step(0,0,0,1,1,1, ALL, 0,0, 2'd2,0, "mw_ack");
    step(0,0,0,1,0,0, ALL, 0,0, 2'd1,0, "mw_after");

    // T4 branch beats load-use and fetch miss
    step(0,1,1,0,0,0, ALL, 1,1, 2'd1,0, "br_wins");

    // T6 counter snapshot after T1..T4
    cnt_pend = 1'b1; pend_ret = 6; pend_lu = 1; pend_mw = 3; pend_br = 1;
    step(0,0,0,1,0,0, ALL, 0,0, 2'd1,0, "t6");

    // Remaining priority cases and single-cycle access
    step(0,0,0,0,0,0, NOPC,1,0, 2'd1,0, "imiss");
    step(0,0,1,1,1,0, NONE,0,0, 2'd1,0, "hold_over_br");
    step(0,1,0,1,1,1, LUS, 0,1, 2'd2,0, "ack_lw");
    step(0,0,0,1,1,1, ALL, 0,0, 2'd1,0, "single");
    step(0,0,0,1,0,0, ALL, 0,0, 2'd1,0, "single_next");

    // Reset in the middle of a DMEM wait abandons the access
    step(0,0,0,1,1,0, NONE,0,0, 2'd1,0, "pre_rst");
    step(0,0,0,1,1,0, NONE,0,0, 2'd2,0, "pre_rst_mw");
    step(1,0,0,1,1,0, NONE,1,1, 2'd2,0, "rst_mw", 1'b0);
    step(0,0,0,1,0,0, NOPC,1,1, 2'd0,0, "init_a");
    step(0,0,0,1,0,0, NOPC,1,1, 2'd0,0, "init_b");
    step(0,0,0,1,0,0, ALL, 0,0, 2'd1,0, "run_b");

    // T5 timeout: 16 wait cycles then HALT, late ACK ignored, RST clears
    step(0,0,0,1,1,0, NONE,0,0, 2'd1,0, "tmo0");
    for (int i = 1; i < 16; i++) step(0,0,0,1,1,0, NONE,0,0, 2'd2,0, "tmo_wait");
    step(0,0,0,1,1,0, NONE,0,0, 2'd3,1, "halt");
    step(0,0,0,1,1,1, NONE,0,0, 2'd3,1, "halt_ack");
    step(0,0,0,1,0,0, NONE,0,0, 2'd3,1, "halt_idle");
    step(1,0,0,1,0,0, NONE,1,1, 2'd3,1, "halt_rst", 1'b0);
    step(1,0,0,1,0,0, NONE,1,1, 2'd0,0, "rst_clr");
    step(0,0,0,1,0,0, NOPC,1,1, 2'd0,0, "init_c");
    step(0,0,0,1,0,0, NOPC,1,1, 2'd0,0, "init_d");
    step(0,0,0,1,0,0, ALL, 0,0, 2'd1,0, "run_c");

    // Drain the scoreboard, bounded
    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
